// File: rtl/apb_slave_mem.sv
// APB completer with a 16-word register window: words 0-14 read/write, word 15 a read-only ID.
// Fixed wait-state insertion, registered response, error on miss/misalignment/ID write.
module apb_slave_mem #(
  parameter int          SEL_BIT     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B2_0014
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer is a setup cycle (sel=1, Penable=0) followed by access cycles
  // (sel=1, Penable=1); it completes in the single cycle where Pready=1, and Pslverr/Prdata
  // are meaningful only in that cycle. Dropping sel or Penable before completion aborts it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        sel;
  logic        load;
  logic        enter_done;
  logic [2:0]  cnt;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [16];

  logic [31:0] eff_addr;
  logic        eff_write;
  logic [3:0]  eff_idx;
  logic        eff_err;
  logic [31:0] word_val;
  logic        unused_sel;

  assign sel        = Pselx[SEL_BIT];
  assign unused_sel = ^Pselx;
  assign dbg_state  = state;

  // With zero wait states DONE is entered on the setup edge itself, so decode the live bus there.
  assign eff_addr  = (state == S_IDLE) ? Paddr  : addr_q;
  assign eff_write = (state == S_IDLE) ? Pwrite : write_q;
  assign eff_idx   = eff_addr[5:2];
  assign eff_err   = (eff_addr[31:6] != BASE_ADDR[31:6]) || (eff_addr[1:0] != 2'b00) ||
                     (eff_write && (eff_idx == 4'd15));
  assign word_val  = (eff_idx == 4'd15) ? ID_VALUE : mem[eff_idx];

  always_ff @(posedge Hclk) begin
    if (Hreset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    enter_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel && !Penable) begin
          load = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sel && Penable) begin
          if (cnt == 3'd1) begin
            state_next = S_DONE;
            enter_done = 1'b1;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      cnt     <= 3'd0;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      Prdata  <= 32'd0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else begin
      if (load) begin
        addr_q  <= Paddr;
        write_q <= Pwrite;
        wdata_q <= Pwdata;
        cnt     <= 3'(WAIT_STATES);
      end else if (state == S_WAIT && sel && Penable) begin
        cnt <= cnt - 3'd1;
      end

      if (enter_done) begin
        Pready  <= 1'b1;
        Pslverr <= eff_err;
        Prdata  <= (!eff_write && !eff_err) ? word_val : 32'd0;
      end else begin
        Pready  <= 1'b0;
        Pslverr <= 1'b0;
        Prdata  <= 32'd0;
      end

      // Pslverr still holds this transfer's error flag while in DONE.
      if (state == S_DONE && write_q && !Pslverr) mem[addr_q[5:2]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with one wait state (select bit 0) and one with
// zero wait states (select bit 1) share the bus; results are compared against a word-array model.
module tb_apb_slave_mem;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B2_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  psel = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;

  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][15];
  logic [31:0] exp_q [$];

  apb_slave_mem #(.SEL_BIT(0), .BASE_ADDR(BASE), .WAIT_STATES(1), .ID_VALUE(ID)) dut_a (
    .Hclk(clk), .Hreset(rst), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(rdata_a), .Pready(ready_a), .Pslverr(err_a),
    .dbg_state(st_a)
  );

  apb_slave_mem #(.SEL_BIT(1), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) dut_b (
    .Hclk(clk), .Hreset(rst), .Pselx(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(rdata_b), .Pready(ready_b), .Pslverr(err_b),
    .dbg_state(st_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: error rule and read value straight from the address map.
  function automatic logic model_err(input logic [31:0] addr, input logic wr);
    return (addr[31:6] != BASE[31:6]) || (addr[1:0] != 2'b00) || (wr && addr[5:2] == 4'd15);
  endfunction

  function automatic logic [31:0] model_rd(input int tgt, input logic [31:0] addr, input logic wr);
    if (wr || model_err(addr, wr)) return 32'd0;
    if (addr[5:2] == 4'd15) return ID;
    return mdl[tgt][addr[5:2]];
  endfunction

  task automatic model_apply(input int tgt, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
    if (wr && !model_err(addr, wr)) mdl[tgt][addr[5:2]] = wdata;
  endtask

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 15; i++) mdl[t][i] = 32'd0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] a = BASE | (32'($urandom_range(0, 14)) << 2);
    if (r == 7) a = a | 32'($urandom_range(1, 3));
    if (r == 8) a = BASE + 32'($urandom_range(1, 1000)) * 32'd64;
    if (r == 9) a = BASE | 32'h3C;
    return a;
  endfunction

  // Driver: setup then access cycles until the target's Pready, bounded; cyc=0 on timeout.
  task automatic xfer(input int tgt, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit scramble,
                      output logic [31:0] rd, output logic er, output int cyc);
    @(negedge clk);
    psel = 3'b001 << tgt; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    rd = 32'd0; er = 1'b0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      penable = 1'b1;
      if (scramble) begin
        paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
      end
      if ((tgt == 1) ? ready_b : ready_a) begin
        cyc = i;
        rd  = (tgt == 1) ? rdata_b : rdata_a;
        er  = (tgt == 1) ? err_b : err_a;
        break;
      end
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (rdata_a !== 32'd0) begin errors++; $display("FAIL reset_rdata_a: got %h want 0", rdata_a); end
    if (ready_a !== 1'b0)  begin errors++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
    if (err_a !== 1'b0)    begin errors++; $display("FAIL reset_err_a: got %b want 0", err_a); end
    if (rdata_b !== 32'd0) begin errors++; $display("FAIL reset_rdata_b: got %h want 0", rdata_b); end
    if (ready_b !== 1'b0)  begin errors++; $display("FAIL reset_ready_b: got %b want 0", ready_b); end
    if (err_b !== 1'b0)    begin errors++; $display("FAIL reset_err_b: got %b want 0", err_b); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0, rd, er, cyc);
    model_apply(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF);
    checks += 2;
    if (cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", cyc); end
    if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
    xfer(0, 1'b0, 32'h8000_0008, 32'd0, 1'b0, rd, er, cyc);
    checks += 3;
    if (cyc !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", cyc); end
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
    bus_idle();
  endtask

  task automatic test_id_word();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b0, 32'h8000_003C, 32'd0, 1'b0, rd, er, cyc);
    checks += 2;
    if (rd !== ID) begin errors++; $display("FAIL id_read: got %h want %h", rd, ID); end
    if (er !== 1'b0) begin errors++; $display("FAIL id_read_err: got %b want 0", er); end
    xfer(0, 1'b1, 32'h8000_003C, 32'h1, 1'b0, rd, er, cyc);
    checks += 1;
    if (er !== 1'b1) begin errors++; $display("FAIL id_write_err: got %b want 1", er); end
    xfer(0, 1'b0, 32'h8000_003C, 32'd0, 1'b0, rd, er, cyc);
    checks += 1;
    if (rd !== ID) begin errors++; $display("FAIL id_reread: got %h want %h", rd, ID); end
    bus_idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] bad [2];
    bad[0] = 32'h8400_0000; bad[1] = 32'h8000_0006;
    for (int i = 0; i < 2; i++) begin
      xfer(0, 1'b0, bad[i], 32'd0, 1'b0, rd, er, cyc);
      checks += 2;
      if (er !== 1'b1) begin errors++; $display("FAIL bad_err[%0d]: got %b want 1", i, er); end
      if (rd !== 32'd0) begin errors++; $display("FAIL bad_data[%0d]: got %h want 0", i, rd); end
    end
    xfer(0, 1'b1, 32'h8000_0006, 32'h5555_AAAA, 1'b0, rd, er, cyc);
    checks += 1;
    if (er !== 1'b1) begin errors++; $display("FAIL misaligned_wr_err: got %b want 1", er); end
    xfer(0, 1'b0, 32'h8000_0004, 32'd0, 1'b0, rd, er, cyc);
    checks += 1;
    if (rd !== mdl[0][1]) begin errors++; $display("FAIL word1_untouched: got %h want %h", rd, mdl[0][1]); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] a, d;
    for (int i = 0; i < 15; i++) begin
      a = BASE | (32'(i) << 2); d = $urandom;
      xfer(1, 1'b1, a, d, 1'b0, rd, er, cyc);
      model_apply(1, 1'b1, a, d);
      checks += 2;
      if (cyc !== 1) begin errors++; $display("FAIL b2b_wr_latency[%0d]: got %0d want 1", i, cyc); end
      if (er !== 1'b0) begin errors++; $display("FAIL b2b_wr_err[%0d]: got %b want 0", i, er); end
    end
    for (int i = 0; i < 15; i++) begin
      a = BASE | (32'(i) << 2);
      xfer(1, 1'b0, a, 32'd0, 1'b0, rd, er, cyc);
      checks += 2;
      if (cyc !== 1) begin errors++; $display("FAIL b2b_rd_latency[%0d]: got %0d want 1", i, cyc); end
      if (rd !== mdl[1][i]) begin errors++; $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rd, mdl[1][i]); end
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int cyc;
    int seen = 0;
    @(negedge clk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0004; pwdata = 32'hCAFE_F00D;
    @(negedge clk);
    penable = 1'b1; psel = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (ready_a) seen++;
      @(negedge clk);
      penable = 1'b0;
    end
    checks += 1;
    if (seen !== 0) begin errors++; $display("FAIL abort_ready: got %0d ready cycles want 0", seen); end
    xfer(0, 1'b0, 32'h8000_0004, 32'd0, 1'b0, rd, er, cyc);
    checks += 1;
    if (rd !== mdl[0][1]) begin errors++; $display("FAIL abort_word1: got %h want %h", rd, mdl[0][1]); end
    bus_idle();
  endtask

  task automatic test_wrong_select();
    int seen = 0;
    int seen_b = 0;
    @(negedge clk);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      penable = 1'b1;
      if (ready_a) seen++;
      if (ready_b) seen_b++;
    end
    checks += 2;
    if (seen !== 0) begin errors++; $display("FAIL wrong_sel_ready: got %0d ready cycles want 0", seen); end
    if (seen_b !== 1) begin errors++; $display("FAIL other_sel_ready: got %0d ready cycles want 1", seen_b); end
    bus_idle();
  endtask

  task automatic test_scramble();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] a, d;
    for (int i = 0; i < 4; i++) begin
      a = BASE | (32'($urandom_range(0, 14)) << 2); d = $urandom;
      xfer(0, 1'b1, a, d, 1'b1, rd, er, cyc);
      model_apply(0, 1'b1, a, d);
      xfer(0, 1'b0, a, 32'd0, 1'b1, rd, er, cyc);
      checks += 2;
      if (rd !== mdl[0][a[5:2]]) begin errors++; $display("FAIL scramble_data[%0d]: got %h want %h", i, rd, mdl[0][a[5:2]]); end
      if (er !== 1'b0) begin errors++; $display("FAIL scramble_err[%0d]: got %b want 0", i, er); end
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] a, d, e;
    logic wr;
    int tgt;
    for (int n = 0; n < 80; n++) begin
      tgt = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a = rand_addr(); d = $urandom;
      exp_q.push_back(model_rd(tgt, a, wr));
      xfer(tgt, wr, a, d, 1'b0, rd, er, cyc);
      e = exp_q.pop_front();
      checks += 3;
      if (cyc !== ((tgt == 1) ? 1 : 2)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, cyc, (tgt == 1) ? 1 : 2); end
      if (er !== model_err(a, wr)) begin errors++; $display("FAIL rnd_err[%0d]: addr %h got %b want %b", n, a, er, model_err(a, wr)); end
      if (rd !== e) begin errors++; $display("FAIL rnd_data[%0d]: addr %h got %h want %h", n, a, rd, e); end
      model_apply(tgt, wr, a, d);
      if ($urandom_range(0, 4) == 0) bus_idle();
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] addrs [3];
    @(negedge clk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0010; pwdata = 32'h1234_5678;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    checks += 1;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL mid_ready_before_reset: got %b want 1", ready_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 3'b000; penable = 1'b0;
    checks += 4;
    if (ready_a !== 1'b0)  begin errors++; $display("FAIL mid_reset_ready: got %b want 0", ready_a); end
    if (err_a !== 1'b0)    begin errors++; $display("FAIL mid_reset_err: got %b want 0", err_a); end
    if (rdata_a !== 32'd0) begin errors++; $display("FAIL mid_reset_rdata: got %h want 0", rdata_a); end
    if (ready_b !== 1'b0)  begin errors++; $display("FAIL mid_reset_ready_b: got %b want 0", ready_b); end
    model_clear();
    addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0010; addrs[2] = 32'h8000_0038;
    for (int i = 0; i < 3; i++) begin
      xfer(0, 1'b0, addrs[i], 32'd0, 1'b0, rd, er, cyc);
      checks += 1;
      if (rd !== 32'd0) begin errors++; $display("FAIL cleared_a[%0d]: got %h want 0", i, rd); end
      xfer(1, 1'b0, addrs[i], 32'd0, 1'b0, rd, er, cyc);
      checks += 1;
      if (rd !== 32'd0) begin errors++; $display("FAIL cleared_b[%0d]: got %h want 0", i, rd); end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_word();
    test_errors();
    test_back_to_back();
    test_abort();
    test_wrong_select();
    test_scramble();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter SEL_BIT, default 0: index of the Pselx bit that selects this completer.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000: 64-byte aligned base of the register window.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0-7: Pready-low cycles inserted in the access phase.
REQ-004 SHALL have parameter ID_VALUE, default 32'hA5B2_0014: read-only content of word 15.
REQ-005 SHALL have port Hclk  in  1: sole clock, rising edge.
REQ-006 SHALL have port Hreset  in  1: reset, synchronous, active-high.
REQ-007 SHALL have port Pselx  in  3: one-hot APB selects from the bridge.
REQ-008 SHALL have port Penable  in  1: APB access-phase strobe.
REQ-009 SHALL have port Pwrite  in  1: 1 = write, 0 = read.
REQ-010 SHALL have port Paddr  in  32: byte address.
REQ-011 SHALL have port Pwdata  in  32: write data.
REQ-012 SHALL have port Prdata  out  32: read data, registered.
REQ-013 SHALL have port Pready  out  1: transfer-complete, registered.
REQ-014 SHALL have port Pslverr  out  1: error response, registered, valid only when Pready=1.

Function
REQ-015 SHALL hold 16 x 32-bit words; words 0-14 read/write, word 15 returns ID_VALUE.
REQ-016 SHALL decode: sel = Pselx[SEL_BIT]; hit = Paddr[31:6]==BASE_ADDR[31:6]; index = Paddr[5:2]; other Pselx bits ignored.
REQ-017 SHALL implement states IDLE, WAIT, DONE.
REQ-018 IDLE: on an edge with sel=1 and Penable=0 (setup), SHALL latch Paddr, Pwrite, Pwdata, load counter with WAIT_STATES, and go to DONE if WAIT_STATES=0, else WAIT.
REQ-019 IDLE: SHALL ignore sel=1 with Penable=1 (no setup seen) and stay in IDLE.
REQ-020 WAIT: on each edge with sel=1 and Penable=1, SHALL decrement the counter and move to DONE on the edge where the counter goes 1->0.
REQ-021 Pready SHALL be 1 exactly while in DONE; first access cycle is cycle 1, so Pready is high in access cycle WAIT_STATES+1.
REQ-022 Prdata and Pslverr SHALL be registered on the edge entering DONE; Prdata = word[index] for an error-free read, else 0.
REQ-023 Pslverr SHALL be 1 in DONE if hit=0, Paddr[1:0]!=0, or (Pwrite=1 and index=15); otherwise 0.
REQ-024 On the edge leaving DONE, a write without error SHALL update word[index] with latched Pwdata; an errored write SHALL change nothing.
REQ-025 DONE SHALL return to IDLE unconditionally after one cycle, clearing Pready, Pslverr and Prdata to 0.
REQ-026 Back-to-back: a setup in the cycle after DONE SHALL be accepted with no dead cycle.
REQ-027 Abort: if sel=0 or Penable=0 in WAIT, SHALL return to IDLE with no write and Pready kept 0.
REQ-028 Inputs SHALL be sampled only at setup; changes to Paddr, Pwrite or Pwdata during WAIT/DONE SHALL have no effect.
REQ-029 Latency: a write is visible to a read whose setup starts in the cycle after its DONE.

Reset
REQ-030 With Hreset=1 at a rising edge, SHALL set state IDLE, counter 0, Pready 0, Pslverr 0, Prdata 0, and words 0-14 to 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no write; a transfer may start on the first edge after reset deasserts.

Verification
REQ-032 Write 32'hDEAD_BEEF to 32'h8000_0008, then read it back with WAIT_STATES=1 -> Pready high in access cycle 2, Prdata=32'hDEAD_BEEF, Pslverr=0.
REQ-033 Read 32'h8000_003C -> Prdata=32'hA5B2_0014, Pslverr=0; write 32'h1 to the same address -> Pslverr=1, later read still returns ID_VALUE.
REQ-034 Read 32'h8400_0000 and read 32'h8000_0006 -> Pslverr=1, Prdata=0, no register changes.
REQ-035 WAIT_STATES=0, back-to-back writes to words 0..14 then reads of all 15 words -> Pready high in access cycle 1 every time, data matches, no idle gaps.
REQ-036 Drop Pselx mid-WAIT on a write to 32'h8000_0004 -> Pready never asserted, word 1 unchanged; assert Hreset mid-transfer -> all outputs 0 on the next cycle and words cleared.
REQ-037 Pselx=3'b010 with SEL_BIT=0 -> no response, Pready stays 0.
